// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: register offsets, STATUS bit positions,
// transmitter state encoding and the divisor clamp rule.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A divisor below 2 cannot be honoured by the baud counter.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO for the UART transmitter; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !rst && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: register decode, baud divisor, 8N1
// framing FSM and registered serial output fed from a small TX FIFO.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV_RST = 868,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [15:0] r_div;
    logic [15:0] r_div_lat;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [CNT_W-1:0] w_count;
    logic        w_bit_end;
    logic        w_tx_next;
    logic        w_busy;
    logic [1:0]  w_reg;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_reg    = addr_i[3:2];
    assign w_push   = we_i && (w_reg == REG_TXDATA);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_unused = &{1'b0, addr_i[31:4], addr_i[1:0], data_i[31:16]};
    assign tx_o     = r_tx;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (data_i[7:0]),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_BUSY]  = w_busy;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_CNT_LSB +: 4] = 4'(w_count);
    end

    always_comb begin
        data_o = '0;
        if (re_i) begin
            case (w_reg)
                REG_STATUS: data_o = w_status;
                REG_DIV:    data_o = {16'h0000, r_div};
                default:    data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= 16'(CLK_DIV_RST);
        end else if (we_i && (w_reg == REG_DIV)) begin
            r_div <= clamp_div(data_i[15:0]);
        end
    end

    assign w_bit_end = (r_baud == r_div_lat - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // tx_o is the registered copy of the current state's line level, so the
    // line trails the state by one clock while every bit still lasts DIV clocks.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_end && (r_bit == 3'd7)) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx      <= 1'b1;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_lat <= 16'(CLK_DIV_RST);
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_shift   <= w_head;
                r_div_lat <= r_div;
                r_baud    <= '0;
                r_bit     <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_bit_end) begin
                    r_baud <= '0;
                    if (r_state == ST_DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: register map, framing, FIFO
// overflow, divisor clamp/latching and mid-frame reset.
module tb_uart_tx;

    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_ST  = 32'h4;
    localparam logic [31:0] A_DIV = 32'h8;
    localparam logic [31:0] A_RSV = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic        re_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [255:0] cap;

    uart_tx #(
        .CLK_DIV_RST (868),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .re_i   (re_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o)
    );

    always #5 clk = ~clk;

    // Expected line level for one frame, sample k at bit k/div.
    function automatic logic [255:0] frame(input logic [7:0] b, input int div);
        logic [255:0] f;
        logic [9:0]   bits;
        f    = '0;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * div; k++) f[k] = bits[k / div];
        return f;
    endfunction

    function automatic logic [255:0] ones(input int n);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < n; k++) f[k] = 1'b1;
        return f;
    endfunction

    // Called at a negedge; the write lands on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; data_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        re_i = 1'b1; addr_i = a;
        #1;
        d = data_o;
        re_i = 1'b0;
    endtask

    task automatic capture(input int n);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            cap[i] = tx_o;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1; we_i = 1'b0; re_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status got=%h exp=00000004", d); end
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd868) begin n_fail++; $display("FAIL reset_div got=%0d exp=868", d); end
        bus_read(A_TX, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read got=%h exp=0", d); end
        bus_read(A_RSV, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rsvd_read got=%h exp=0", d); end
        addr_i = A_DIV; re_i = 1'b0; #1; n_tests++;
        if (data_o !== 32'h0) begin n_fail++; $display("FAIL read_idle got=%h exp=0", data_o); end
    endtask

    task automatic test_single_frame;
        logic [31:0]  d;
        logic [255:0] e;
        @(negedge clk);
        bus_write(A_DIV, 32'd4);
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL div_write got=%0d exp=4", d); end
        bus_write(A_TX, 32'h55);
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL sf_tx_n0 got=%b exp=1", tx_o); end
        @(negedge clk);
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL sf_tx_n1 got=%b exp=1", tx_o); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL sf_busy got=%h exp=00000005", d); end
        @(negedge clk);
        capture(40);
        e = frame(8'h55, 4);
        n_tests++;
        if (cap !== e) begin n_fail++; $display("FAIL sf_frame got=%h exp=%h", cap[39:0], e[39:0]); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL sf_idle got=%h exp=00000004", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0]  d;
        logic [255:0] e;
        bus_write(A_DIV, 32'd4);
        we_i = 1'b1; addr_i = A_TX; data_i = 32'h41;
        @(negedge clk); data_i = 32'h42;
        @(negedge clk); data_i = 32'h43;
        @(negedge clk); we_i = 1'b0;
        capture(120);
        e = frame(8'h41, 4) | (frame(8'h42, 4) << 40) | (frame(8'h43, 4) << 80);
        n_tests++;
        if (cap !== e) begin n_fail++; $display("FAIL b2b_frames got=%h exp=%h", cap[119:0], e[119:0]); end
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL b2b_tail got=%b exp=1", tx_o); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL b2b_idle got=%h exp=00000004", d); end
    endtask

    task automatic test_fifo_full;
        logic [31:0] d;
        logic [9:0]  bits;
        logic [9:0]  e;
        bus_write(A_DIV, 32'd100);
        we_i = 1'b1; addr_i = A_TX;
        for (int i = 0; i < 6; i++) begin
            data_i = 32'h10 + 32'(i);
            @(negedge clk);
        end
        we_i = 1'b0;
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h43) begin n_fail++; $display("FAIL ff_status got=%h exp=00000043", d); end
        repeat (47) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 10; b++) begin
                bits[b] = tx_o;
                repeat (100) @(negedge clk);
            end
            e = {1'b1, 8'(8'h10 + f), 1'b0};
            n_tests++;
            if (bits !== e) begin n_fail++; $display("FAIL ff_frame%0d got=%b exp=%b", f, bits, e); end
        end
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL ff_no_6th got=%b exp=1", tx_o); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL ff_idle got=%h exp=00000004", d); end
    endtask

    task automatic test_div_clamp;
        logic [31:0] d;
        bus_write(A_DIV, 32'd1);
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL clamp_1 got=%0d exp=2", d); end
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL clamp_0 got=%0d exp=2", d); end
        bus_write(A_DIV, 32'hABCD_0003);
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL div_3 got=%0d exp=3", d); end
        we_i = 1'b1; re_i = 1'b1; addr_i = A_DIV; data_i = 32'd6;
        #1; d = data_o; re_i = 1'b0;
        @(negedge clk); we_i = 1'b0;
        n_tests++;
        if (d !== 32'd3) begin n_fail++; $display("FAIL rw_old got=%0d exp=3", d); end
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd6) begin n_fail++; $display("FAIL rw_new got=%0d exp=6", d); end
    endtask

    task automatic test_div_change;
        logic [255:0] e;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'hA5);
        bus_write(A_TX, 32'h3C);
        bus_write(A_DIV, 32'd8);
        capture(120);
        e = frame(8'hA5, 4) | (frame(8'h3C, 8) << 40);
        n_tests++;
        if (cap !== e) begin n_fail++; $display("FAIL divchg_frames got=%h exp=%h", cap[119:0], e[119:0]); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0]  d;
        logic [255:0] e;
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h0B);
        bus_write(A_TX, 32'hF0);
        repeat (14) @(negedge clk);
        n_tests++;
        if (tx_o !== 1'b0) begin n_fail++; $display("FAIL rm_bit2 got=%b exp=0", tx_o); end
        rst = 1'b1; we_i = 1'b1; addr_i = A_TX; data_i = 32'h77;
        @(negedge clk);
        rst = 1'b0; we_i = 1'b0;
        n_tests++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL rm_tx got=%b exp=1", tx_o); end
        bus_read(A_ST, d); n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL rm_status got=%h exp=00000004", d); end
        bus_read(A_DIV, d); n_tests++;
        if (d !== 32'd868) begin n_fail++; $display("FAIL rm_div got=%0d exp=868", d); end
        capture(60);
        e = ones(60);
        n_tests++;
        if (cap !== e) begin n_fail++; $display("FAIL rm_residual got=%h exp=%h", cap[59:0], e[59:0]); end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_fifo_full;
        test_div_clamp;
        test_div_change;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
